// File: rtl/kronos_obi_master_arbiter.sv
// kronos_obi_master_arbiter: N-to-1 OBI master arbiter feeding one external xbar
// master slot. Round-robin selection, in-order response routing, sticky error.
//
// Ports:
//   clk_i, rst_i    : clock, synchronous active-high reset
//   master_req_i    : upstream OBI requests, one per master
//   master_resp_o   : upstream gnt / rvalid / rdata, one per master
//   slave_req_o     : merged request towards the xbar master slot
//   slave_resp_i    : gnt / rvalid / rdata from the xbar master slot
//   protocol_err_o  : sticky, set on rvalid with nothing outstanding
//   stall_cnt_o     : per-master stall cycle counters
//
// Optional feature macro: KRONOS_ARB_STALL_CNT_EN enables the saturating stall
// counters; when undefined stall_cnt_o is tied to zero.

package kronos_obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

module kronos_obi_master_arbiter
    import kronos_obi_pkg::*;
#(
    parameter int unsigned NUM_MASTERS     = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  obi_req_t                     master_req_i  [NUM_MASTERS],
    output obi_resp_t                    master_resp_o [NUM_MASTERS],
    output obi_req_t                     slave_req_o,
    input  obi_resp_t                    slave_resp_i,
    output logic                         protocol_err_o,
    output logic [NUM_MASTERS-1:0][31:0] stall_cnt_o
);

    localparam int unsigned SEL_W = $clog2(NUM_MASTERS);
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef logic [SEL_W-1:0] sel_t;

    sel_t                   rr_ptr;
    sel_t                   lock_idx;
    logic                   locked;
    sel_t                   sel_rr;
    sel_t                   sel;
    sel_t                   head;
    sel_t                   fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [NUM_MASTERS-1:0] req_vec;
    logic [NUM_MASTERS-1:0] gnt_vec;
    logic [NUM_MASTERS-1:0] rv_vec;
    logic                   full;
    logic                   empty;
    logic                   fwd_req;
    logic                   hs;
    logic                   pop;
    logic                   spurious;

    always_comb begin
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            req_vec[i] = master_req_i[i].req;
        end
    end

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        int   idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        sel_rr = rr_ptr;
        for (int k = 0; k < int'(NUM_MASTERS); k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= int'(NUM_MASTERS)) begin
                idx = idx - int'(NUM_MASTERS);
            end
            if (!found && req_vec[idx]) begin
                sel_rr = sel_t'(idx);
                found  = 1'b1;
            end
        end
    end

    // A presented-but-ungranted request keeps its master until the grant.
    assign sel      = locked ? lock_idx : sel_rr;
    assign full     = (count == CNT_W'(MAX_OUTSTANDING));
    assign empty    = (count == '0);
    assign fwd_req  = req_vec[sel] & ~full & ~rst_i;
    assign hs       = fwd_req & slave_resp_i.gnt;
    assign head     = fifo_q[rd_ptr];
    assign pop      = slave_resp_i.rvalid & ~empty & ~rst_i;
    assign spurious = slave_resp_i.rvalid & empty & ~rst_i;

    always_comb begin
        slave_req_o     = master_req_i[sel];
        slave_req_o.req = fwd_req;
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            gnt_vec[i]              = hs & (sel == sel_t'(i));
            rv_vec[i]               = pop & (head == sel_t'(i));
            master_resp_o[i].gnt    = gnt_vec[i];
            master_resp_o[i].rvalid = rv_vec[i];
            master_resp_o[i].rdata  = slave_resp_i.rdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr         <= '0;
            locked         <= 1'b0;
            lock_idx       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            if (hs) begin
                locked <= 1'b0;
                wr_ptr <= wr_ptr + 1'b1;
                if (sel == sel_t'(NUM_MASTERS - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= sel + 1'b1;
                end
            end else if (fwd_req) begin
                locked   <= 1'b1;
                lock_idx <= sel;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({hs, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (spurious) begin
                protocol_err_o <= 1'b1;
            end
        end
    end

    // Routing storage needs no reset: entries are only read below count.
    always_ff @(posedge clk_i) begin
        if (hs) begin
            fifo_q[wr_ptr] <= sel;
        end
    end

`ifdef KRONOS_ARB_STALL_CNT_EN
    logic [NUM_MASTERS-1:0][31:0] stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_MASTERS); i++) begin
                if (req_vec[i] && !gnt_vec[i] && (stall_q[i] != 32'hFFFF_FFFF)) begin
                    stall_q[i] <= stall_q[i] + 32'd1;
                end
            end
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_kronos_obi_master_arbiter.sv
// tb_kronos_obi_master_arbiter: randomized scoreboard bench for the OBI arbiter.
// Stimulus pushes expected outputs from a queue-based model; a monitor compares.

module tb_kronos_obi_master_arbiter;
    import kronos_obi_pkg::*;

    localparam int N = 3;
    localparam int D = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    obi_req_t             mreq  [N];
    obi_resp_t            mresp [N];
    obi_req_t             sreq;
    obi_resp_t            sresp;
    logic                 perr;
    logic [N-1:0][31:0]   stall;

    kronos_obi_master_arbiter #(
        .NUM_MASTERS     (N),
        .MAX_OUTSTANDING (D)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .master_req_i   (mreq),
        .master_resp_o  (mresp),
        .slave_req_o    (sreq),
        .slave_resp_i   (sresp),
        .protocol_err_o (perr),
        .stall_cnt_o    (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               req;
        logic               we;
        logic [3:0]         be;
        logic [31:0]        addr;
        logic [31:0]        wdata;
        logic [N-1:0]       gnt;
        logic [N-1:0]       rv;
        logic [31:0]        rdata;
        logic               err;
        logic [N-1:0][31:0] stall;
    } exp_t;

    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state
    int          rr = 0;
    int          cur = -1;
    int          outq [$];
    bit          err_m = 0;
    logic [31:0] stall_m [N];
    bit          act [N];
    obi_req_t    pend [N];

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, x, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t         e;
        logic [N-1:0] g;
        logic [N-1:0] v;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 0; i < N; i++) begin
                g[i] = mresp[i].gnt;
                v[i] = mresp[i].rvalid;
            end
            chk("slave_req", sreq.req, e.req);
            if (e.req) begin
                chk("slave_fields", {sreq.we, sreq.be, sreq.addr, sreq.wdata},
                    {e.we, e.be, e.addr, e.wdata});
            end
            chk("gnt_vec", g, e.gnt);
            chk("rvalid_vec", v, e.rv);
            for (int i = 0; i < N; i++) begin
                if (e.rv[i]) chk("rdata", mresp[i].rdata, e.rdata);
            end
            chk("protocol_err", perr, e.err);
            for (int i = 0; i < N; i++) begin
                chk("stall_cnt", stall[i], e.stall[i]);
            end
        end
    end

    task automatic cycle(input bit r, input int p_req, input int p_gnt,
                         input int p_rv, input bit spur);
        exp_t e;
        int   s;
        bit   full;
        bit   hs;
        bit   pop;
        rst = r;
        for (int i = 0; i < N; i++) begin
            if (!act[i] && $urandom_range(99) < p_req) begin
                act[i]        = 1'b1;
                pend[i].we    = 1'($urandom_range(1));
                pend[i].be    = 4'($urandom);
                pend[i].addr  = $urandom;
                pend[i].wdata = $urandom;
            end
            mreq[i]     = pend[i];
            mreq[i].req = act[i];
        end
        sresp.gnt    = ($urandom_range(99) < p_gnt);
        sresp.rvalid = !r && (outq.size() > 0 || spur) && ($urandom_range(99) < p_rv);
        sresp.rdata  = $urandom;

        full = (outq.size() == D);
        s = -1;
        if (cur >= 0) begin
            s = cur;
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (rr + k) % N;
                if (s < 0 && act[j]) s = j;
            end
        end
        e.req   = !r && (s >= 0) && !full;
        e.we    = 1'b0;
        e.be    = '0;
        e.addr  = '0;
        e.wdata = '0;
        e.gnt   = '0;
        e.rv    = '0;
        e.rdata = '0;
        if (e.req) begin
            e.we    = pend[s].we;
            e.be    = pend[s].be;
            e.addr  = pend[s].addr;
            e.wdata = pend[s].wdata;
        end
        hs = e.req && sresp.gnt;
        if (hs) e.gnt[s] = 1'b1;
        pop = sresp.rvalid && (outq.size() > 0);
        if (pop) begin
            e.rv[outq[0]] = 1'b1;
            e.rdata       = sresp.rdata;
        end
        e.err = err_m;
        for (int i = 0; i < N; i++) begin
`ifdef KRONOS_ARB_STALL_CNT_EN
            e.stall[i] = stall_m[i];
`else
            e.stall[i] = '0;
`endif
        end
        sb.push_back(e);

        @(posedge clk);
        #1;

        if (r) begin
            rr    = 0;
            cur   = -1;
            err_m = 0;
            outq.delete();
            for (int i = 0; i < N; i++) stall_m[i] = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (act[i] && !e.gnt[i] && stall_m[i] != 32'hFFFF_FFFF) stall_m[i]++;
            end
            if (pop) void'(outq.pop_front());
            if (sresp.rvalid && !pop) err_m = 1;
            if (hs) begin
                outq.push_back(s);
                rr     = (s + 1) % N;
                cur    = -1;
                act[s] = 1'b0;
            end else if (e.req) begin
                cur = s;
            end
        end
    endtask

    int p_req [4] = '{60, 95, 95, 40};
    int p_gnt [4] = '{70, 25, 90, 60};
    int p_rv  [4] = '{50, 40, 10, 90};

    initial begin
        bit busy;
        sresp = '0;
        for (int i = 0; i < N; i++) begin
            act[i]     = 1'b0;
            pend[i]    = '0;
            mreq[i]    = '0;
            stall_m[i] = '0;
        end
        @(posedge clk);
        #1;
        // Reset held with everyone requesting
        cycle(1, 100, 100, 0, 0);
        cycle(1, 100, 100, 0, 0);
        // Round-robin until the routing FIFO fills, then pop releases it
        repeat (6) cycle(0, 100, 100, 0, 0);
        cycle(0, 100, 100, 100, 0);
        repeat (4) cycle(0, 100, 100, 100, 0);
        // Randomized phases
        for (int ph = 0; ph < 4; ph++) begin
            repeat (500) cycle(0, p_req[ph], p_gnt[ph], p_rv[ph], 0);
        end
        cycle(1, 50, 50, 0, 0);
        repeat (300) cycle(0, 70, 60, 60, 0);
        // Drain, then a response with nothing outstanding
        for (int k = 0; k < 60; k++) begin
            busy = (outq.size() > 0);
            for (int i = 0; i < N; i++) busy |= act[i];
            if (busy) cycle(0, 0, 100, 100, 0);
        end
        cycle(0, 0, 100, 100, 1);
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
